// File: rtl/johnson_phase_decoder_pkg.sv
// Shared definitions for the Johnson phase decoder: lock FSM encoding and
// the phase index width helper.
package johnson_phase_decoder_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_TRACK    = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

    // Bits needed to index the 2N phases of an N-bit Johnson counter.
    function automatic int phase_width(input int n);
        return (n < 1) ? 1 : $clog2(2 * n);
    endfunction

endpackage

// File: rtl/johnson_phase_decoder_code_check.sv
// Combinational legality check and phase decode of one Johnson state word.
// Legal words are a contiguous run of ones anchored at the MSB or the LSB.
module johnson_code_check
    import johnson_phase_decoder_pkg::*;
#(
    parameter  int N  = 4,
    localparam int PW = phase_width(N)
) (
    input  logic [N-1:0]  code_i,
    output logic          legal_o,
    output logic [PW-1:0] phase_o
);

    int   ones;
    logic msb_ok;
    logic lsb_ok;

    // Popcount plus the two run-shape tests; phase folds back after all-ones.
    always_comb begin
        ones   = 0;
        msb_ok = 1'b1;
        lsb_ok = 1'b1;
        for (int i = 0; i < N; i++) begin
            ones = ones + int'(code_i[i]);
        end
        for (int i = 1; i < N; i++) begin
            if (!code_i[i] && code_i[i-1]) msb_ok = 1'b0;
            if (code_i[i] && !code_i[i-1]) lsb_ok = 1'b0;
        end
        legal_o = msb_ok | lsb_ok;
        if (code_i[N-1] || (ones == 0)) begin
            phase_o = PW'(ones);
        end else begin
            phase_o = PW'(2 * N - ones);
        end
    end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Registers and decodes the Johnson counter state, classifies each step,
// tracks lock, and keeps revolution and error counts.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   ST_UNLOCKED  | no reference sample; next legal sample becomes one
//   ST_TRACK     | reference held, counting clean advances toward lock
//   ST_LOCKED    | counter running cleanly; revolutions are counted
module johnson_phase_decoder
    import johnson_phase_decoder_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int LOCK_CNT = 4,
    parameter  int REV_W    = 16,
    parameter  int ERR_W    = 8,
    localparam int PW       = phase_width(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     jc_in_i,
    input  logic             jc_valid_i,
    input  logic             clr_counts_i,
    output logic [PW-1:0]    phase_o,
    output logic [2*N-1:0]   phase_onehot_o,
    output logic             phase_valid_o,
    output logic             illegal_o,
    output logic             seq_err_o,
    output logic             locked_o,
    output logic [REV_W-1:0] rev_count_o,
    output logic [ERR_W-1:0] err_count_o
);

    localparam int NP = 2 * N;
    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam logic [PW-1:0] LAST_PHASE = PW'(NP - 1);

    logic             chk_legal;
    logic [PW-1:0]    chk_phase;

    lock_state_t      state_q;
    logic [CW-1:0]    good_cnt_q;
    logic [PW-1:0]    ref_phase_q;
    logic [PW-1:0]    phase_q;
    logic [NP-1:0]    onehot_q;
    logic             phase_valid_q;
    logic             illegal_q;
    logic             seq_err_q;
    logic             locked_q;
    logic [REV_W-1:0] rev_q;
    logic [ERR_W-1:0] err_q;

    logic [PW-1:0]    exp_next;
    logic             have_ref;
    logic             is_hold;
    logic             is_adv;
    logic             is_seq;
    logic             is_wrap;
    logic             err_event;

    johnson_code_check #(.N(N)) u_check (
        .code_i  (jc_in_i),
        .legal_o (chk_legal),
        .phase_o (chk_phase)
    );

    // Step classification of the current word against the stored reference.
    always_comb begin
        exp_next  = (ref_phase_q == LAST_PHASE) ? '0 : ref_phase_q + PW'(1);
        have_ref  = (state_q != ST_UNLOCKED);
        is_hold   = chk_legal && have_ref && (chk_phase == ref_phase_q);
        is_adv    = chk_legal && have_ref && (chk_phase == exp_next);
        is_seq    = chk_legal && have_ref && !is_hold && !is_adv;
        is_wrap   = jc_valid_i && is_adv && (state_q == ST_LOCKED)
                    && (ref_phase_q == LAST_PHASE);
        err_event = jc_valid_i && (!chk_legal || is_seq);
    end

    // Sample register, decoded outputs and lock FSM; a rejected sample never
    // becomes the reference, so the next legal one restarts tracking cleanly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_UNLOCKED;
            good_cnt_q    <= '0;
            ref_phase_q   <= '0;
            phase_q       <= '0;
            onehot_q      <= '0;
            phase_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            seq_err_q <= 1'b0;
            if (jc_valid_i) begin
                if (!chk_legal) begin
                    illegal_q     <= 1'b1;
                    phase_valid_q <= 1'b0;
                    onehot_q      <= '0;
                    state_q       <= ST_UNLOCKED;
                    locked_q      <= 1'b0;
                end else begin
                    phase_q       <= chk_phase;
                    phase_valid_q <= 1'b1;
                    onehot_q      <= NP'(1) << chk_phase;
                    case (state_q)
                        ST_UNLOCKED: begin
                            state_q     <= ST_TRACK;
                            good_cnt_q  <= '0;
                            ref_phase_q <= chk_phase;
                            locked_q    <= 1'b0;
                        end
                        ST_TRACK: begin
                            if (is_seq) begin
                                seq_err_q <= 1'b1;
                                state_q   <= ST_UNLOCKED;
                            end else if (is_adv) begin
                                ref_phase_q <= chk_phase;
                                good_cnt_q  <= good_cnt_q + CW'(1);
                                if (good_cnt_q == CW'(LOCK_CNT - 1)) begin
                                    state_q  <= ST_LOCKED;
                                    locked_q <= 1'b1;
                                end
                            end
                        end
                        ST_LOCKED: begin
                            if (is_seq) begin
                                seq_err_q <= 1'b1;
                                state_q   <= ST_UNLOCKED;
                                locked_q  <= 1'b0;
                            end else begin
                                ref_phase_q <= chk_phase;
                            end
                        end
                        default: begin
                            state_q  <= ST_UNLOCKED;
                            locked_q <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    // Revolution counter wraps; error counter saturates; clear has priority.
    always_ff @(posedge clk) begin
        if (reset || clr_counts_i) begin
            rev_q <= '0;
            err_q <= '0;
        end else begin
            if (is_wrap) rev_q <= rev_q + REV_W'(1);
            if (err_event && (err_q != {ERR_W{1'b1}})) err_q <= err_q + ERR_W'(1);
        end
    end

    assign phase_o        = phase_q;
    assign phase_onehot_o = onehot_q;
    assign phase_valid_o  = phase_valid_q;
    assign illegal_o      = illegal_q;
    assign seq_err_o      = seq_err_q;
    assign locked_o       = locked_q;
    assign rev_count_o    = rev_q;
    assign err_count_o    = err_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Self-checking bench for johnson_phase_decoder: a table-driven behavioural
// model compared every cycle, plus literal expectations at key points.
module tb_johnson_phase_decoder;

    localparam int N        = 4;
    localparam int NP       = 2 * N;
    localparam int LOCK_CNT = 4;
    localparam int REV_W    = 16;
    localparam int ERR_W    = 8;
    localparam int PW       = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     jc_in = 4'b1010;
    logic             jc_valid = 1'b1;
    logic             clr_counts = 1'b0;
    logic [PW-1:0]    phase;
    logic [NP-1:0]    phase_onehot;
    logic             phase_valid;
    logic             illegal;
    logic             seq_err;
    logic             locked;
    logic [REV_W-1:0] rev_count;
    logic [ERR_W-1:0] err_count;

    johnson_phase_decoder #(
        .N(N), .LOCK_CNT(LOCK_CNT), .REV_W(REV_W), .ERR_W(ERR_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .jc_in_i        (jc_in),
        .jc_valid_i     (jc_valid),
        .clr_counts_i   (clr_counts),
        .phase_o        (phase),
        .phase_onehot_o (phase_onehot),
        .phase_valid_o  (phase_valid),
        .illegal_o      (illegal),
        .seq_err_o      (seq_err),
        .locked_o       (locked),
        .rev_count_o    (rev_count),
        .err_count_o    (err_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit started  = 1'b0;

    // Model state: expected outputs plus reference/lock bookkeeping.
    int e_phase, e_pv, e_ill, e_seq, e_locked, e_rev, e_err;
    int have_ref, ref_ph, good;

    // Johnson word for phase k: ones fill in from the MSB, then drain from it.
    function automatic logic [N-1:0] jcode(input int k);
        int unsigned code;
        if (k <= N) code = ((32'd1 << k) - 1) << (N - k);
        else        code = (32'd1 << (NP - k)) - 1;
        return code[N-1:0];
    endfunction

    function automatic int lookup(input logic [N-1:0] c);
        for (int k = 0; k < NP; k++) begin
            if (jcode(k) == c) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int idx, wrap, ev;
        wrap = 0;
        ev   = 0;
        if (reset) begin
            e_phase = 0; e_pv = 0; e_ill = 0; e_seq = 0; e_locked = 0;
            e_rev = 0; e_err = 0; have_ref = 0; ref_ph = 0; good = 0;
        end else begin
            e_ill = 0;
            e_seq = 0;
            if (jc_valid) begin
                idx = lookup(jc_in);
                if (idx < 0) begin
                    e_ill = 1; e_pv = 0; have_ref = 0; e_locked = 0; ev = 1;
                end else begin
                    e_phase = idx;
                    e_pv    = 1;
                    if (have_ref == 0) begin
                        have_ref = 1; ref_ph = idx; good = 0;
                    end else if (idx != ref_ph) begin
                        if (idx == (ref_ph + 1) % NP) begin
                            if (e_locked != 0 && ref_ph == NP - 1) wrap = 1;
                            ref_ph = idx;
                            if (e_locked == 0) begin
                                good++;
                                if (good == LOCK_CNT) e_locked = 1;
                            end
                        end else begin
                            e_seq = 1; have_ref = 0; e_locked = 0; ev = 1;
                        end
                    end
                end
            end
            if (clr_counts) begin
                e_rev = 0;
                e_err = 0;
            end else begin
                e_rev = (e_rev + wrap) % (1 << REV_W);
                if (ev != 0 && e_err < (1 << ERR_W) - 1) e_err++;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("phase",   32'(phase),        32'(e_phase));
            chk("onehot",  32'(phase_onehot), (e_pv != 0) ? (32'd1 << e_phase) : 32'd0);
            chk("pvalid",  32'(phase_valid),  32'(e_pv));
            chk("illegal", 32'(illegal),      32'(e_ill));
            chk("seq_err", 32'(seq_err),      32'(e_seq));
            chk("locked",  32'(locked),       32'(e_locked));
            chk("rev",     32'(rev_count),    32'(e_rev));
            chk("err",     32'(err_count),    32'(e_err));
        end
    end

    task automatic drive(input logic [N-1:0] c, input logic v, input logic cl);
        @(negedge clk);
        reset      = 1'b0;
        jc_in      = c;
        jc_valid   = v;
        clr_counts = cl;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        started = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_phase",  32'(phase), 0);
        chk("rst_onehot", 32'(phase_onehot), 0);
        chk("rst_pvalid", 32'(phase_valid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err",    32'(err_count), 0);

        drive(4'b0000, 1, 0); settle();
        chk("run_p0", 32'(phase), 0);
        chk("run_pv", 32'(phase_valid), 1);
        drive(4'b1000, 1, 0);
        drive(4'b1100, 1, 0);
        drive(4'b1110, 1, 0); settle();
        chk("run_p3", 32'(phase), 3);
        chk("run_nolock", 32'(locked), 0);
        drive(4'b1111, 1, 0); settle();
        chk("run_p4", 32'(phase), 4);
        chk("run_onehot4", 32'(phase_onehot), 32'h10);
        chk("run_lock", 32'(locked), 1);

        drive(4'b0111, 1, 0);
        drive(4'b0011, 1, 0);
        drive(4'b0001, 1, 0); settle();
        chk("run_p7", 32'(phase), 7);
        drive(4'b0000, 1, 0); settle();
        chk("rev1", 32'(rev_count), 1);
        for (int k = 1; k <= 16; k++) drive(jcode(k % NP), 1, 0);
        settle();
        chk("rev3", 32'(rev_count), 3);

        drive(4'b1010, 1, 0); settle();
        chk("ill_pulse", 32'(illegal), 1);
        chk("ill_pv", 32'(phase_valid), 0);
        chk("ill_onehot", 32'(phase_onehot), 0);
        chk("ill_unlock", 32'(locked), 0);
        chk("ill_err", 32'(err_count), 1);
        drive(4'b0011, 1, 0); settle();
        chk("newref_seq", 32'(seq_err), 0);
        chk("newref_p6", 32'(phase), 6);

        drive(4'b0001, 1, 0);
        drive(4'b0000, 1, 0);
        drive(4'b1000, 1, 0);
        drive(4'b1110, 1, 0); settle();
        chk("seq_pulse", 32'(seq_err), 1);
        chk("seq_ill", 32'(illegal), 0);
        chk("seq_err_cnt", 32'(err_count), 2);
        drive(4'b1100, 1, 0); settle();
        chk("seq_first", 32'(seq_err), 0);
        drive(4'b1010, 0, 0); settle();
        chk("gap_ill", 32'(illegal), 0);
        chk("gap_phase", 32'(phase), 2);
        drive(4'b0101, 0, 0);
        drive(4'b1100, 1, 0); settle();
        chk("hold_seq", 32'(seq_err), 0);
        chk("hold_err", 32'(err_count), 2);

        for (int i = 0; i < 260; i++) drive(4'b1010, 1, 0);
        settle();
        chk("sat_255", 32'(err_count), 255);
        drive(4'b0110, 1, 0); settle();
        chk("sat_hold", 32'(err_count), 255);
        chk("sat_ill", 32'(illegal), 1);

        for (int k = 0; k < NP; k++) drive(jcode(k), 1, 0);
        settle();
        chk("pre_clr_lock", 32'(locked), 1);
        drive(4'b0000, 1, 1); settle();
        chk("clr_rev", 32'(rev_count), 0);
        chk("clr_err", 32'(err_count), 0);
        for (int k = 1; k <= NP; k++) drive(jcode(k % NP), 1, 0);
        settle();
        chk("post_clr_rev", 32'(rev_count), 1);

        @(negedge clk);
        reset      = 1'b1;
        jc_in      = 4'b1000;
        jc_valid   = 1'b1;
        clr_counts = 1'b0;
        settle();
        chk("mid_rst_lock", 32'(locked), 0);
        chk("mid_rst_rev", 32'(rev_count), 0);
        chk("mid_rst_pv", 32'(phase_valid), 0);
        @(negedge clk);
        reset    = 1'b0;
        jc_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
